// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and helpers for the run-time clock divider controller.
package clk_div_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    RUN    = 2'd1,
    SWITCH = 2'd2
  } state_t;

  function automatic int div_w(input int max_n);
    return $clog2(max_n + 1);
  endfunction

  function automatic logic div_legal(input int n, input int max_n);
    return (n >= 2) && (n <= max_n);
  endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Divide-ratio request port: valid/ready handshake plus an error pulse back.
interface clk_div_ctrl_if #(
  parameter int MAX_N = 16
);
  import clk_div_ctrl_pkg::*;

  localparam int W = div_w(MAX_N);

  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;

  modport master (output cfg_valid, output cfg_div, input cfg_ready, input cfg_err);
  modport slave  (input cfg_valid, input cfg_div, output cfg_ready, output cfg_err);

endinterface

// File: rtl/clk_div_core.sv
// Dual-edge counter pair and gated decode giving a 50% duty clock for any ratio.
module clk_div_core
  import clk_div_ctrl_pkg::*;
#(
  parameter int MAX_N = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    hold,
  input  logic                    run,
  input  logic [div_w(MAX_N)-1:0] div,
  output logic                    wrap,
  output logic                    clk_out
);
  localparam int W = div_w(MAX_N);

  logic [W-1:0] pos_cnt;
  logic [W-1:0] neg_cnt;
  logic [W-1:0] last;
  logic [W-1:0] half;
  logic         odd_hi;
  logic         even_hi;

  assign last = div - W'(1);
  assign half = div >> 1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_cnt <= '0;
    end else if (hold || (pos_cnt >= last)) begin
      pos_cnt <= '0;
    end else begin
      pos_cnt <= pos_cnt + W'(1);
    end
  end

  // Runs half a cycle ahead of pos_cnt; supplies the extra half-cycle for odd ratios.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      neg_cnt <= '0;
    end else if (hold || (neg_cnt >= last)) begin
      neg_cnt <= '0;
    end else begin
      neg_cnt <= neg_cnt + W'(1);
    end
  end

  assign wrap    = run && (pos_cnt == last);
  assign odd_hi  = (pos_cnt > half) || (neg_cnt > half);
  assign even_hi = (pos_cnt >= half);
  assign clk_out = run && (div[0] ? odd_hi : even_hi);

endmodule

// File: rtl/clk_div_ctrl.sv
// Sequences ratio changes and start/stop of the divided clock on period boundaries.
//   state  | meaning
//   OFF    | output low, counters held, ratio may be loaded directly
//   RUN    | divided clock running at cur_div
//   SWITCH | output forced low for GAP cycles, then pending ratio applied
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int MAX_N     = 16,
  parameter int DEFAULT_N = 4,
  parameter int GAP       = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  clk_div_ctrl_if.slave           cfg,
  output logic [div_w(MAX_N)-1:0] cur_div,
  output logic                    busy,
  output logic                    clk_out
);
  localparam int W  = div_w(MAX_N);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t        state;
  logic          pend_vld;
  logic [W-1:0]  pend_div;
  logic [GW-1:0] gap_cnt;
  logic          err;
  logic          xfer;
  logic          legal;
  logic          wrap;
  logic          run;
  logic          hold;

  assign run           = (state == RUN);
  assign hold          = !run;
  assign legal         = div_legal(int'(cfg.cfg_div), MAX_N);
  assign cfg.cfg_ready = (state != SWITCH) && !pend_vld;
  assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg.cfg_err   = err;
  assign busy          = (state == SWITCH) || pend_vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= OFF;
      cur_div  <= W'(DEFAULT_N);
      pend_vld <= 1'b0;
      pend_div <= '0;
      gap_cnt  <= '0;
      err      <= 1'b0;
    end else begin
      err <= xfer && !legal;
      case (state)
        OFF: begin
          // A request latched on the same edge RUN stopped is absorbed here.
          if (xfer && legal) begin
            cur_div <= cfg.cfg_div;
          end else if (pend_vld) begin
            cur_div  <= pend_div;
            pend_vld <= 1'b0;
          end
          if (enable) state <= RUN;
        end
        RUN: begin
          if (xfer && legal) begin
            pend_vld <= 1'b1;
            pend_div <= cfg.cfg_div;
          end
          if (wrap) begin
            if (pend_vld) begin
              state   <= SWITCH;
              gap_cnt <= GW'(GAP - 1);
            end else if (!enable) begin
              state <= OFF;
            end
          end
        end
        SWITCH: begin
          if (gap_cnt == '0) begin
            cur_div  <= pend_div;
            pend_vld <= 1'b0;
            state    <= enable ? RUN : OFF;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= OFF;
      endcase
    end
  end

  clk_div_core #(.MAX_N(MAX_N)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (hold),
    .run     (run),
    .div     (cur_div),
    .wrap    (wrap),
    .clk_out (clk_out)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: vector table, corner sequences, random requests vs pulse model.
module tb_clk_div_ctrl;
  localparam int MAX_N     = 16;
  localparam int DEFAULT_N = 4;
  localparam int GAP       = 2;
  localparam int W         = $clog2(MAX_N + 1);

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable  = 1'b0;
  logic [W-1:0] cur_div;
  logic         busy;
  logic         clk_out;

  int total = 0;
  int bad   = 0;

  // Reference model: ratio in force and whether the next low pulse spans a switch gap.
  int exp_n   = DEFAULT_N;
  bit sw_pend = 1'b0;
  bit mon_on  = 1'b0;

  typedef struct {
    int div;
    int exp_err;
    int exp_cur;
  } vec_t;

  vec_t tbl[8];
  int   pat4[8];

  clk_div_ctrl_if #(.MAX_N(MAX_N)) cfg_if ();

  clk_div_ctrl #(.MAX_N(MAX_N), .DEFAULT_N(DEFAULT_N), .GAP(GAP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .cfg     (cfg_if),
    .cur_div (cur_div),
    .busy    (busy),
    .clk_out (clk_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pulse monitor: one sample per half clk cycle; high = N halves, low = N or 2*GAP+N.
  logic prev_out = 1'b0;
  int   hi_len   = 0;
  int   lo_len   = 0;
  bit   synced   = 1'b0;

  always begin
    @(clk);
    #1;
    if (!mon_on) begin
      synced = 1'b0;
      hi_len = 0;
      lo_len = 0;
    end else if (clk_out == prev_out) begin
      if (clk_out) hi_len++;
      else lo_len++;
    end else if (clk_out) begin
      if (synced) begin
        if (sw_pend) check("switch low length", lo_len, 2 * GAP + exp_n);
        else check("low length", lo_len, exp_n);
      end
      sw_pend = 1'b0;
      synced  = 1'b1;
      hi_len  = 1;
    end else begin
      if (synced) check("high length", hi_len, exp_n);
      lo_len = 1;
    end
    prev_out = clk_out;
  end

  task automatic send(input int d);
    int n;
    n = 0;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = W'(d);
    while (!cfg_if.cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready wait", int'(cfg_if.cfg_ready), 1);
    @(posedge clk);
    #1;
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic do_req(input int d);
    bit leg;
    int n;
    leg = (d >= 2) && (d <= MAX_N);
    send(d);
    check("err after accept", int'(cfg_if.cfg_err), int'(!leg));
    check("busy after accept", int'(busy), int'(leg));
    check("ready after accept", int'(cfg_if.cfg_ready), int'(!leg));
    if (leg) begin
      n = 0;
      while (busy && n < 60) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("switch done", int'(busy), 0);
      exp_n   = d;
      sw_pend = 1'b1;
    end else begin
      @(posedge clk);
      #1;
      check("err one cycle", int'(cfg_if.cfg_err), 0);
    end
    check("cur_div", int'(cur_div), exp_n);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  held;
    bit  found;
    logic prev;

    tbl[0] = '{3, 0, 3};
    tbl[1] = '{1, 1, 3};
    tbl[2] = '{17, 1, 3};
    tbl[3] = '{0, 1, 3};
    tbl[4] = '{16, 0, 16};
    tbl[5] = '{31, 1, 16};
    tbl[6] = '{2, 0, 2};
    tbl[7] = '{3, 0, 3};
    pat4   = '{0, 0, 1, 1, 0, 0, 1, 1};

    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst clk_out", int'(clk_out), 0);
    check("rst cur_div", int'(cur_div), DEFAULT_N);
    check("rst ready", int'(cfg_if.cfg_ready), 1);
    check("rst err", int'(cfg_if.cfg_err), 0);
    check("rst busy", int'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("off clk_out", int'(clk_out), 0);

    // Start with the default ratio
    @(negedge clk);
    enable  = 1'b1;
    exp_n   = DEFAULT_N;
    sw_pend = 1'b0;
    mon_on  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("N4 wave", int'(clk_out), pat4[i]);
    end
    check("N4 cur_div", int'(cur_div), 4);
    repeat (8) @(posedge clk);

    // Ratio 7, then two illegal requests
    do_req(7);
    repeat (30) @(posedge clk);
    do_req(1);
    do_req(17);
    repeat (10) @(posedge clk);

    // Ratio 5, drop enable at pos_cnt=1, period completes then stop
    do_req(5);
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("N5 last high", int'(clk_out), 1);
    @(posedge clk);
    #1;
    check("stop low", int'(clk_out), 0);
    mon_on = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("off stays low", int'(clk_out), 0);
    end
    check("off busy", int'(busy), 0);

    // OFF-state config table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_div   = W'(tbl[i].div);
      @(posedge clk);
      #1;
      cfg_if.cfg_valid = 1'b0;
      check("tbl err", int'(cfg_if.cfg_err), tbl[i].exp_err);
      check("tbl cur_div", int'(cur_div), tbl[i].exp_cur);
      check("tbl busy", int'(busy), 0);
      check("tbl clk_out", int'(clk_out), 0);
    end

    // Restart at ratio 3
    @(negedge clk);
    exp_n   = 3;
    sw_pend = 1'b0;
    mon_on  = 1'b1;
    enable  = 1'b1;
    repeat (20) @(posedge clk);

    // Back-to-back 6 then 9
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = W'(6);
    @(posedge clk);
    #1;
    check("6 accepted", int'(busy), 1);
    cfg_if.cfg_div = W'(9);
    held = 1'b1;
    n    = 0;
    while (busy && n < 60) begin
      if (cfg_if.cfg_ready) held = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    check("9 held off", int'(held), 1);
    check("6 switch done", int'(busy), 0);
    exp_n   = 6;
    sw_pend = 1'b1;
    check("cur_div 6", int'(cur_div), 6);
    @(posedge clk);
    #1;
    cfg_if.cfg_valid = 1'b0;
    check("9 accepted", int'(busy), 1);
    n = 1;
    while (busy && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("9 latency", n, 6 + GAP);
    exp_n   = 9;
    sw_pend = 1'b1;
    check("cur_div 9", int'(cur_div), 9);
    repeat (30) @(posedge clk);

    // Reset asserted mid-SWITCH
    send(8);
    prev  = clk_out;
    found = 1'b0;
    n     = 0;
    while (!found && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (prev && !clk_out) found = 1'b1;
      prev = clk_out;
    end
    check("reached boundary", int'(found), 1);
    check("switch busy", int'(busy), 1);
    check("switch ready", int'(cfg_if.cfg_ready), 0);
    #2;
    mon_on  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async rst clk_out", int'(clk_out), 0);
    check("async rst cur_div", int'(cur_div), DEFAULT_N);
    check("async rst busy", int'(busy), 0);
    check("async rst ready", int'(cfg_if.cfg_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    check("held rst clk_out", int'(clk_out), 0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_n   = DEFAULT_N;
    sw_pend = 1'b0;
    mon_on  = 1'b1;
    repeat (10) @(posedge clk);

    // Random requests against the pulse model
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 12)) @(posedge clk);
      do_req(int'($urandom_range(0, 20)));
    end
    repeat (40) @(posedge clk);
    mon_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
